master_port: RTL and testbench
==============================

// Module: master_port
// PURPOSE
//  Master-side endpoint of the serial system bus: upstream counterpart of the slave
//  top. Accepts one parallel read/write request from a master device, requests the bus
//  from the arbiter, serialises address (and write data) onto the bus, deserialises
//  read data returned by the slave, and reports completion, with a timeout on reads.
// PARAMETERS
//  ADDR_WIDTH  12  address bits shifted onto the bus per transaction
//  DATA_WIDTH  8   data bits per transaction
//  TIMEOUT     64  max idle cycles in read-wait before abort (>=2)
// PORTS
//  clk      in   1           clock, all logic on rising edge
//  rstn     in   1           synchronous active-low reset
//  dvalid   in   1           device request valid
//  dmode    in   1           0 read, 1 write
//  daddr    in   ADDR_WIDTH  request address
//  dwdata   in   DATA_WIDTH  write data
//  dready   out  1           port idle, request accepted when dvalid&dready
//  drdata   out  DATA_WIDTH  last read data (held until next read completes)
//  ddone    out  1           1-cycle completion pulse
//  derr     out  1           valid with ddone: read timed out
//  breq     out  1           bus request to arbiter
//  bgrant   in   1           bus granted
//  mwdata   out  1           serial address/write-data bit (LSB first)
//  mrdata   in   1           serial read-data bit from slave
//  mmode    out  1           mode, valid while mvalid=1, else 0
//  mvalid   out  1           mwdata valid
//  svalid   in   1           mrdata valid
//  sready   in   1           slave ready for transaction
// BEHAVIOUR
//  - Reset (rstn=0 at edge): state IDLE, counters 0; breq, mvalid, mwdata, mmode,
//    ddone, derr=0; drdata=0. dready=(state==IDLE), so 1 from first reset edge.
//    Reset mid-transfer truncates it at once; no ddone issued.
//  - All outputs are registered or decoded from state only; no input->output comb path.
//  - States: IDLE, REQ, ADDR, WDATA, RWAIT, DONE.
//  - IDLE: on dvalid=1 capture daddr/dwdata/dmode -> REQ. dvalid ignored outside IDLE.
//  - REQ: breq=1. When bgrant=1 and sready=1 in same cycle -> ADDR; else stay
//    (no timeout here).
//  - ADDR: breq=1, mvalid=1, mmode=captured mode, mwdata=addr[cnt], cnt 0..ADDR_WIDTH-1,
//    one bit per cycle. After bit ADDR_WIDTH-1: write -> WDATA, read -> RWAIT.
//  - WDATA: mvalid=1, mwdata=wdata[cnt], cnt 0..DATA_WIDTH-1, contiguous with ADDR
//    (write = ADDR_WIDTH+DATA_WIDTH consecutive mvalid cycles). Last bit -> DONE.
//  - RWAIT: breq=1, mvalid=0. Each cycle with svalid=1 shifts mrdata into bit[rcnt],
//    LSB first. Gaps in svalid allowed. Idle counter clears on each sampled bit,
//    else increments; after DATA_WIDTH bits -> DONE with derr=0, drdata=shifted word.
//    Idle counter reaching TIMEOUT -> DONE with derr=1, drdata=0.
//  - DONE: one cycle, ddone=1, breq=0, then IDLE. dready first high the cycle after DONE.
//  - breq deasserts only in DONE/IDLE. bgrant drop mid-transfer is ignored; the
//    arbiter holds the grant while breq=1.
//  - Latency, write with immediate grant: accept edge -> REQ(1) -> ADDR_WIDTH+
//    DATA_WIDTH bit cycles -> DONE. 2+ADDR_WIDTH+DATA_WIDTH cycles to ddone.
//  - svalid outside RWAIT is ignored. Counters sized $clog2 of their max value + 1;
//    no wrap inside a transfer.
// TESTING
//  1. Write daddr=0x5A3 dwdata=0xC6, grant+sready high -> mvalid 20 contiguous cycles,
//     mwdata = 1,1,0,0,0,1,0,1,1,0,1,0 then 0,1,1,0,0,0,1,1; mmode=1; ddone 1 cycle;
//     derr=0.
//  2. Read daddr=0x010, slave drives 0x3D on svalid 5 cycles after address, with a
//     2-cycle svalid gap -> drdata=0x3D, ddone=1, derr=0, mmode=0 during address.
//  3. Read, svalid never asserted -> ddone with derr=1, drdata=0 exactly TIMEOUT
//     cycles after RWAIT entry; breq low in DONE.
//  4. bgrant=1 but sready=0 for 10 cycles -> breq=1, mvalid=0 throughout, address
//     starts the cycle after sready rises.
//  5. dvalid pulsed with new daddr during a write -> ignored, captured transfer
//     bits unchanged, dready=0.
//  6. rstn=0 for one edge at address bit 4 -> next cycle mvalid=0, breq=0, ddone=0,
//     dready=1; a new request then completes normally.

Source files
------------

// File: rtl/master_port.sv
// master_port: master-side endpoint of the serial system bus.
// It takes one parallel read/write request from a device and arbitrates for the bus.
// It then shifts the address, plus the write data on a write, out LSB first.
// On a read it collects the serial read data, or gives up after TIMEOUT idle cycles.
// Every output is a register or a decode of the current state.
module master_port #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  dvalid,
    input  logic                  dmode,
    input  logic [ADDR_WIDTH-1:0] daddr,
    input  logic [DATA_WIDTH-1:0] dwdata,
    output logic                  dready,
    output logic [DATA_WIDTH-1:0] drdata,
    output logic                  ddone,
    output logic                  derr,
    output logic                  breq,
    input  logic                  bgrant,
    output logic                  mwdata,
    input  logic                  mrdata,
    output logic                  mmode,
    output logic                  mvalid,
    input  logic                  svalid,
    input  logic                  sready
);

    localparam int BIT_MAX = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CW      = $clog2(BIT_MAX) + 1;
    localparam int TW      = $clog2(TIMEOUT) + 1;

    localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_WIDTH - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);
    localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [TW-1:0] IDLE_ONE  = TW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_ADDR,
        S_WDATA,
        S_RWAIT,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_WIDTH-1:0] r_addr;      // shifted right once per address bit
    logic [DATA_WIDTH-1:0] r_wdata;     // shifted right once per write-data bit
    logic [DATA_WIDTH-1:0] r_rshift;    // read bits enter at the MSB, LSB first overall
    logic [DATA_WIDTH-1:0] r_drdata;
    logic                  r_mode;
    logic                  r_err;
    logic [CW-1:0]         r_cnt;
    logic [TW-1:0]         r_idle;
    logic                  w_addr_last;
    logic                  w_data_last;
    logic                  w_idle_last;
    logic [DATA_WIDTH-1:0] w_rword;

    assign w_addr_last = (r_cnt == ADDR_LAST);
    assign w_data_last = (r_cnt == DATA_LAST);
    assign w_idle_last = (r_idle == IDLE_LAST);
    assign w_rword     = {mrdata, r_rshift[DATA_WIDTH-1:1]};
    assign drdata      = r_drdata;

    // State register with synchronous reset.
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and the state-decoded bus/device outputs.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        w_state_next = r_state;
        dready       = 1'b0;
        breq         = 1'b0;
        mvalid       = 1'b0;
        mmode        = 1'b0;
        mwdata       = 1'b0;
        ddone        = 1'b0;
        derr         = 1'b0;
        case (r_state)
            S_IDLE: begin
                dready = 1'b1;
                if (dvalid) w_state_next = S_REQ;
            end
            S_REQ: begin
                breq = 1'b1;
                if (bgrant && sready) w_state_next = S_ADDR;
            end
            S_ADDR: begin
                breq   = 1'b1;
                mvalid = 1'b1;
                mmode  = r_mode;
                mwdata = r_addr[0];
                if (w_addr_last) w_state_next = r_mode ? S_WDATA : S_RWAIT;
            end
            S_WDATA: begin
                breq   = 1'b1;
                mvalid = 1'b1;
                mmode  = r_mode;
                mwdata = r_wdata[0];
                if (w_data_last) w_state_next = S_DONE;
            end
            S_RWAIT: begin
                breq = 1'b1;
                if (svalid) begin
                    if (w_data_last) w_state_next = S_DONE;
                end else if (w_idle_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                ddone        = 1'b1;
                derr         = r_err;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath: request capture, serial shifting, read assembly and the idle timer.
    always_ff @(posedge clk) begin
        // NOTE: the datapath is reset as well, so drdata reads 0 right after reset.
        if (!rstn) begin
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rshift <= '0;
            r_drdata <= '0;
            r_mode   <= 1'b0;
            r_err    <= 1'b0;
            r_cnt    <= '0;
            r_idle   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt  <= '0;
                    r_idle <= '0;
                    if (dvalid) begin
                        r_addr  <= daddr;
                        r_wdata <= dwdata;
                        r_mode  <= dmode;
                        r_err   <= 1'b0;
                    end
                end
                S_ADDR: begin
                    r_addr <= r_addr >> 1;
                    r_cnt  <= w_addr_last ? '0 : r_cnt + CNT_ONE;
                end
                S_WDATA: begin
                    r_wdata <= r_wdata >> 1;
                    r_cnt   <= r_cnt + CNT_ONE;
                end
                S_RWAIT: begin
                    if (svalid) begin
                        r_rshift <= w_rword;
                        r_cnt    <= r_cnt + CNT_ONE;
                        r_idle   <= '0;
                        if (w_data_last) r_drdata <= w_rword;
                    end else begin
                        r_idle <= r_idle + IDLE_ONE;
                        if (w_idle_last) begin
                            r_drdata <= '0;
                            r_err    <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_cnt  <= '0;
                    r_idle <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_master_port.sv
// tb_master_port: a transaction-level reference model for master_port.
// Requests are randomised, and so are the arbitration delays, the read-data gaps and the timeouts.
// The bench also plays the arbiter and the slave, and drives noise on inputs the port must ignore.
module tb_master_port;

    localparam int AW = 12;
    localparam int DW = 8;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          rstn;
    logic          dvalid;
    logic          dmode;
    logic [AW-1:0] daddr;
    logic [DW-1:0] dwdata;
    logic          dready;
    logic [DW-1:0] drdata;
    logic          ddone;
    logic          derr;
    logic          breq;
    logic          bgrant;
    logic          mwdata;
    logic          mrdata;
    logic          mmode;
    logic          mvalid;
    logic          svalid;
    logic          sready;

    int            n_total = 0;
    int            n_bad   = 0;
    logic [DW-1:0] exp_drdata;
    int            gaps[DW];

    master_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rstn(rstn), .dvalid(dvalid), .dmode(dmode), .daddr(daddr),
        .dwdata(dwdata), .dready(dready), .drdata(drdata), .ddone(ddone), .derr(derr),
        .breq(breq), .bgrant(bgrant), .mwdata(mwdata), .mrdata(mrdata), .mmode(mmode),
        .mvalid(mvalid), .svalid(svalid), .sready(sready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One complete device transaction: the bench acts as arbiter and slave and checks everything against the model.
    task automatic run_txn(input logic mode, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                           input logic [DW-1:0] rd, input int gdelay, input bit tmo);
        int              t;
        int              v;
        int              first_mv = -1;
        int              last_mv  = -1;
        int              n_mv     = 0;
        int              s0       = -1;
        int              done_t   = -1;
        int              mmode_bad = 0;
        int              breq_bad  = 0;
        int              busy_bad  = 0;
        int              q_len;
        int              exp_first;
        int              exp_done;
        int              q[$];
        logic            got_err = 1'b0;
        logic [DW-1:0]   got_rd  = '0;
        logic [AW+DW-1:0] bits   = '0;
        logic [AW+DW-1:0] one_b  = 1;
        logic [AW+DW-1:0] exp_bits;

        // Slave response schedule: -1 is an idle cycle, 0/1 is a data bit.
        if (!mode && !tmo) begin
            for (int i = 0; i < DW; i++) begin
                repeat (gaps[i]) q.push_back(-1);
                q.push_back(int'(rd[i]));
            end
        end
        q_len = q.size();

        @(negedge clk);
        check("start_dready", 32'(dready), 32'd1);
        dvalid = 1'b1;
        dmode  = mode;
        daddr  = addr;
        dwdata = wd;
        bgrant = 1'($urandom);
        sready = 1'b0;
        svalid = 1'($urandom);
        mrdata = 1'($urandom);

        for (t = 1; t <= 400 && done_t < 0; t++) begin
            @(negedge clk);
            // Observe the outputs produced by the previous rising edge.
            if (mvalid) begin
                if (first_mv < 0) first_mv = t;
                last_mv = t;
                if (n_mv < AW + DW && mwdata) bits = bits | (one_b << n_mv);
                n_mv++;
                if (mmode !== mode) mmode_bad++;
            end else if (mmode !== 1'b0) begin
                mmode_bad++;
            end
            if (ddone) begin
                done_t  = t;
                got_err = derr;
                got_rd  = drdata;
                check("breq_in_done", 32'(breq), 32'd0);
                check("dready_in_done", 32'(dready), 32'd0);
            end else begin
                if (!breq) breq_bad++;
                if (dready || derr) busy_bad++;
            end
            // Device side: stray requests while busy must be ignored.
            dvalid = ddone ? 1'b0 : ($urandom_range(0, 3) == 0);
            daddr  = AW'($urandom);
            dwdata = DW'($urandom);
            dmode  = 1'($urandom);
            // Arbiter/slave readiness: hold one of them low until the chosen cycle.
            if (t >= 1 + gdelay) begin
                bgrant = 1'b1;
                sready = 1'b1;
            end else begin
                case ($urandom_range(0, 2))
                    0:       begin bgrant = 1'b1; sready = 1'b0; end
                    1:       begin bgrant = 1'b0; sready = 1'b1; end
                    default: begin bgrant = 1'b0; sready = 1'b0; end
                endcase
            end
            // Slave read data once the address is through; noise otherwise.
            if (!mode && s0 < 0 && n_mv == AW && !mvalid) s0 = t;
            if (s0 >= 0 && !ddone) begin
                if (q.size() > 0) begin
                    v      = q.pop_front();
                    svalid = (v >= 0);
                    mrdata = (v >= 0) ? v[0] : 1'($urandom);
                end else begin
                    svalid = 1'b0;
                    mrdata = 1'($urandom);
                end
            end else begin
                svalid = 1'($urandom);
                mrdata = 1'($urandom);
            end
        end
        dvalid = 1'b0;
        svalid = 1'b0;

        check("ddone_seen", 32'(done_t >= 0), 32'd1);
        if (done_t < 0) return;

        exp_first = 2 + gdelay;
        exp_bits  = mode ? {wd, addr} : {{DW{1'b0}}, addr};
        if (mode) exp_done = exp_first + AW + DW;
        else      exp_done = exp_first + AW + (tmo ? TO : q_len);
        if (!mode) exp_drdata = tmo ? '0 : rd;

        check("first_mvalid", 32'(first_mv), 32'(exp_first));
        check("mvalid_count", 32'(n_mv), mode ? 32'(AW + DW) : 32'(AW));
        check("mvalid_contig", 32'(last_mv - first_mv + 1), 32'(n_mv));
        check("serial_bits", 32'(bits), 32'(exp_bits));
        check("mmode", 32'(mmode_bad), 32'd0);
        check("breq_busy", 32'(breq_bad), 32'd0);
        check("dready_busy", 32'(busy_bad), 32'd0);
        check("ddone_time", 32'(done_t), 32'(exp_done));
        check("derr", 32'(got_err), 32'(!mode && tmo));
        check("drdata", 32'(got_rd), 32'(exp_drdata));

        @(negedge clk);
        check("ddone_pulse", 32'(ddone), 32'd0);
        check("dready_after", 32'(dready), 32'd1);
        check("drdata_held", 32'(drdata), 32'(exp_drdata));
    endtask

    // A write is truncated by a one-edge reset while address bit 4 is on the bus.
    task automatic reset_mid_transfer();
        int n = 0;
        @(negedge clk);
        dvalid = 1'b1;
        dmode  = 1'b1;
        daddr  = AW'($urandom);
        dwdata = DW'($urandom);
        bgrant = 1'b1;
        sready = 1'b1;
        for (int t = 0; t < 50 && n < 5; t++) begin
            @(negedge clk);
            dvalid = 1'b0;
            if (mvalid) n++;
        end
        check("rst_reached_bit4", 32'(n), 32'd5);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        exp_drdata = '0;
        check("rst_mvalid", 32'(mvalid), 32'd0);
        check("rst_breq", 32'(breq), 32'd0);
        check("rst_ddone", 32'(ddone), 32'd0);
        check("rst_dready", 32'(dready), 32'd1);
        check("rst_drdata", 32'(drdata), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic m;
        bit   tmo;
        rstn       = 1'b0;
        dvalid     = 1'b0;
        dmode      = 1'b0;
        daddr      = '0;
        dwdata     = '0;
        bgrant     = 1'b0;
        sready     = 1'b0;
        svalid     = 1'b0;
        mrdata     = 1'b0;
        exp_drdata = '0;
        foreach (gaps[i]) gaps[i] = 0;
        repeat (3) @(negedge clk);
        check("reset_dready", 32'(dready), 32'd1);
        check("reset_breq", 32'(breq), 32'd0);
        check("reset_mvalid", 32'(mvalid), 32'd0);
        check("reset_mwdata", 32'(mwdata), 32'd0);
        check("reset_mmode", 32'(mmode), 32'd0);
        check("reset_ddone", 32'(ddone), 32'd0);
        check("reset_derr", 32'(derr), 32'd0);
        check("reset_drdata", 32'(drdata), 32'd0);
        rstn = 1'b1;

        // Directed: write with immediate grant.
        run_txn(1'b1, 12'h5A3, 8'hC6, 8'h00, 0, 1'b0);
        // Directed: read with a 5-cycle response delay and a 2-cycle gap.
        gaps[0] = 5;
        gaps[4] = 2;
        run_txn(1'b0, 12'h010, 8'h00, 8'h3D, 0, 1'b0);
        foreach (gaps[i]) gaps[i] = 0;
        // Directed: read timeout.
        run_txn(1'b0, AW'($urandom), 8'h00, DW'($urandom), 0, 1'b1);
        // Directed: long arbitration stall.
        run_txn(1'b1, AW'($urandom), DW'($urandom), 8'h00, 10, 1'b0);
        // Directed: reset mid-address, then a normal request.
        reset_mid_transfer();
        run_txn(1'b1, AW'($urandom), DW'($urandom), 8'h00, 1, 1'b0);

        // Random transactions.
        for (int k = 0; k < 30; k++) begin
            m   = 1'($urandom);
            tmo = !m && ($urandom_range(0, 5) == 0);
            foreach (gaps[i]) gaps[i] = $urandom_range(0, 4);
            run_txn(m, AW'($urandom), DW'($urandom), DW'($urandom), $urandom_range(0, 6), tmo);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
